sti_dac_banked: RTL

Parametrised serial-transmit / byte-reassembly block that succeeds the fixed four-bank STI_DAC. Parallel words are framed to 8/16/24/32 bits and shifted out one bit per clock. The same bitstream is regrouped into bytes and written into NUM_BANKS odd/even memory pairs using a checkerboard interleave. After `pi_end`, remaining memory is zero-padded and completion is flagged. A `pi_ready` handshake is added so upstream never loads into a busy shifter.

---
 rtl/sti_dac_banked.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sti_dac_banked.sv
// Serial transmitter with byte reassembly into NUM_BANKS odd/even memory pairs.
// Frames of 8/16/24/32 bits go out one bit per clock; bytes land in a checkerboard interleave.
module sti_dac_banked #(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned ROW_BYTES  = 8,
  localparam int unsigned ADDR_W    = $clog2(BANK_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [15:0]          pi_data,
  input  logic [1:0]           pi_length,
  input  logic                 pi_fill,
  input  logic                 pi_msb,
  input  logic                 pi_low,
  input  logic                 pi_end,
  output logic                 pi_ready,
  output logic                 so_data,
  output logic                 so_valid,
  output logic [7:0]           oem_dataout,
  output logic [ADDR_W-1:0]    oem_addr,
  output logic [NUM_BANKS-1:0] odd_wr,
  output logic [NUM_BANKS-1:0] even_wr,
  output logic                 oem_finish
);

  localparam int unsigned TOTAL = 2 * NUM_BANKS * BANK_DEPTH;
  localparam int unsigned K_W   = $clog2(TOTAL + 1);
  localparam int unsigned LOC_W = ADDR_W + 1;
  localparam int unsigned ROW_W = $clog2(ROW_BYTES);
  localparam int unsigned G_W   = K_W - LOC_W;
  localparam logic [K_W-1:0] TOTAL_K = K_W'(TOTAL);

  typedef enum logic [1:0] {StIdle, StShift, StPad, StDone} state_e;

  state_e                state_q, state_d;
  logic [31:0]           sh_q, sh_d;
  logic                  msb_q, msb_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [7:0]            byte_q, byte_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [NUM_BANKS-1:0]  odd_q, odd_d, even_q, even_d;
  logic [7:0]            dout_q, dout_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;

  logic        load_acc, end_acc, so_bit, pad, wr_en, parity;
  logic [31:0] frame, frame_al;
  logic [5:0]  nbits;
  logic [7:0]  wr_data;
  logic [2:0]  pad_shift;
  logic [G_W-1:0] bank_sel;

  assign pi_ready   = reset && (state_q == StIdle);
  assign load_acc   = pi_ready && load;
  assign end_acc    = pi_ready && !load && pi_end;
  assign so_valid   = (state_q == StShift);
  assign so_bit     = msb_q ? sh_q[31] : sh_q[0];
  assign so_data    = so_valid && so_bit;
  assign oem_finish = (state_q == StDone);
  assign odd_wr     = odd_q;
  assign even_wr    = even_q;
  assign oem_dataout = dout_q;
  assign oem_addr   = addr_q;

  // Frame is right-aligned in 32 bits; MSB-first frames are left-aligned so bit 31 leads.
  always_comb begin
    frame = '0;
    nbits = 6'd8;
    case (pi_length)
      2'd0: begin
        frame = {24'h0, (pi_low ? pi_data[15:8] : pi_data[7:0])};
        nbits = 6'd8;
      end
      2'd1: begin
        frame = {16'h0, pi_data};
        nbits = 6'd16;
      end
      2'd2: begin
        frame = pi_fill ? {8'h0, pi_data, 8'h00} : {16'h0, pi_data};
        nbits = 6'd24;
      end
      default: begin
        frame = pi_fill ? {pi_data, 16'h0000} : {16'h0, pi_data};
        nbits = 6'd32;
      end
    endcase
    frame_al = pi_msb ? (frame << (6'd32 - nbits)) : frame;
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    msb_d     = msb_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    bcnt_d    = bcnt_q;
    k_d       = k_q;
    pad       = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    pad_shift = 3'(4'd8 - {1'b0, bcnt_q});

    case (state_q)
      StIdle: begin
        if (load_acc) begin
          state_d = StShift;
          sh_d    = frame_al;
          msb_d   = pi_msb;
          cnt_d   = nbits;
        end else if (end_acc) begin
          pad = 1'b1;
        end
      end
      StShift: begin
        sh_d   = msb_q ? (sh_q << 1) : (sh_q >> 1);
        cnt_d  = cnt_q - 6'd1;
        byte_d = {byte_q[6:0], so_bit};
        bcnt_d = bcnt_q + 3'd1;
        if (cnt_q == 6'd1) state_d = StIdle;
        // Once memory is full the byte still assembles but is dropped.
        if (bcnt_q == 3'd7 && k_q != TOTAL_K) begin
          wr_en   = 1'b1;
          wr_data = byte_d;
        end
      end
      StPad:   pad = 1'b1;
      default: ;
    endcase

    if (pad) begin
      if (k_q == TOTAL_K) begin
        state_d = StDone;
      end else begin
        state_d = StPad;
        wr_en   = 1'b1;
        wr_data = (bcnt_q != 3'd0) ? (byte_q << pad_shift) : 8'h00;
        byte_d  = 8'h00;
        bcnt_d  = 3'd0;
      end
    end

    if (wr_en) k_d = k_q + 1'b1;
  end

  // Strobe placement is derived from the pre-increment byte index.
  assign bank_sel = k_q[K_W-1:LOC_W];
  assign parity   = k_q[0] ^ k_q[ROW_W];

  always_comb begin
    odd_d  = '0;
    even_d = '0;
    dout_d = dout_q;
    addr_d = addr_q;
    if (wr_en) begin
      dout_d = wr_data;
      addr_d = k_q[ADDR_W:1];
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (bank_sel == G_W'(b)) begin
          if (parity) odd_d[b] = 1'b1;
          else        even_d[b] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      sh_q    <= '0;
      msb_q   <= 1'b0;
      cnt_q   <= '0;
      byte_q  <= '0;
      bcnt_q  <= '0;
      k_q     <= '0;
      odd_q   <= '0;
      even_q  <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      msb_q   <= msb_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      bcnt_q  <= bcnt_d;
      k_q     <= k_d;
      odd_q   <= odd_d;
      even_q  <= even_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
    end
  end

endmodule
